// File: rtl/xbar_pkg.sv
// Shared definitions for the N x N round-robin crossbar: counter width and a
// lane-slice helper for packed per-lane vectors.
package xbar_pkg;

  localparam int CNT_W    = 16;
  localparam int VEC_MAX  = 256;
  localparam int LANE_MAX = 32;

  // Returns lane idx of width w from a packed vector (lanes up to LANE_MAX bits).
  function automatic logic [LANE_MAX-1:0] lane_slice(input logic [VEC_MAX-1:0] vec,
                                                     input int idx, input int w);
    logic [VEC_MAX-1:0] mask;
    mask = {VEC_MAX{1'b1}} >> (VEC_MAX - w);
    return LANE_MAX'((vec >> (idx * w)) & mask);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches req upward from ptr (mod N) and
// grants the first set bit when en is high.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int DW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [DW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [DW-1:0] gnt_idx,
  output logic          any
);

  logic [DW-1:0] idx;

  // N is a power of two, so DW-bit addition wraps modulo N.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    idx     = '0;
    for (int k = 0; k < N; k++) begin
      idx = ptr + DW'(k);
      if (en && !any && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/crossbar_nxn_rr.sv
// N x N registered crossbar with per-output round-robin arbitration and
// valid/ready flow control. Define XBAR_CNT_EN to add per-output grant counters.
module crossbar_nxn_rr
  import xbar_pkg::*;
#(
  parameter int N  = 4,
  parameter int W  = 4,
  parameter int DW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    in_valid,
  output logic [N-1:0]    in_ready,
  input  logic [N*DW-1:0] in_dest,
  input  logic [N*W-1:0]  in_data,
  output logic [N-1:0]    out_valid,
  input  logic [N-1:0]    out_ready,
  output logic [N*DW-1:0] out_src,
  output logic [N*W-1:0]  out_data
`ifdef XBAR_CNT_EN
  ,
  output logic [N*CNT_W-1:0] out_cnt
`endif
);

  logic [DW-1:0] dest      [N];
  logic [N-1:0]  req       [N];
  logic [N-1:0]  gnt       [N];
  logic [DW-1:0] gidx      [N];
  logic [N-1:0]  any_g;
  logic [N-1:0]  free;
  logic [W-1:0]  gdata     [N];

  logic [N-1:0]  vld_p1;
  logic [W-1:0]  data_p1   [N];
  logic [DW-1:0] src_p1    [N];
  logic [DW-1:0] ptr_p1    [N];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      dest[i] = '0;
      dest[i] = DW'(lane_slice(VEC_MAX'(in_dest), i, DW));
    end
    for (int j = 0; j < N; j++) begin
      req[j] = '0;
      for (int i = 0; i < N; i++)
        req[j][i] = in_valid[i] && (dest[i] == DW'(j));
    end
  end

  // An input requests only one output, so OR-ing grants across outputs is safe.
  always_comb begin
    in_ready = '0;
    for (int j = 0; j < N; j++)
      for (int i = 0; i < N; i++)
        if (rst_n && gnt[j][i]) in_ready[i] = 1'b1;
  end

  for (genvar j = 0; j < N; j++) begin : g_out
    assign free[j] = ~vld_p1[j] | out_ready[j];
    assign gdata[j] = W'(lane_slice(VEC_MAX'(in_data), int'(gidx[j]), W));

    rr_arbiter #(.N(N), .DW(DW)) u_arb (
      .req     (req[j]),
      .ptr     (ptr_p1[j]),
      .en      (free[j]),
      .gnt     (gnt[j]),
      .gnt_idx (gidx[j]),
      .any     (any_g[j])
    );

    assign out_data[j*W +: W]   = data_p1[j];
    assign out_src[j*DW +: DW]  = src_p1[j];
  end

  assign out_valid = vld_p1;

  // ---- stage p1: output holding registers ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= '0;
      for (int j = 0; j < N; j++) begin
        data_p1[j] <= '0;
        src_p1[j]  <= '0;
        ptr_p1[j]  <= '0;
      end
    end else begin
      for (int j = 0; j < N; j++) begin
        if (any_g[j]) begin
          vld_p1[j]  <= 1'b1;
          data_p1[j] <= gdata[j];
          src_p1[j]  <= gidx[j];
          ptr_p1[j]  <= gidx[j] + DW'(1);
        end else if (out_ready[j]) begin
          vld_p1[j]  <= 1'b0;
        end
      end
    end
  end

`ifdef XBAR_CNT_EN
  logic [CNT_W-1:0] cnt_p1 [N];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < N; j++) cnt_p1[j] <= '0;
    end else begin
      for (int j = 0; j < N; j++)
        if (any_g[j]) cnt_p1[j] <= cnt_p1[j] + CNT_W'(1);
    end
  end

  for (genvar j = 0; j < N; j++) begin : g_cnt
    assign out_cnt[j*CNT_W +: CNT_W] = cnt_p1[j];
  end
`endif

endmodule

// File: tb/tb_crossbar_nxn_rr.sv
// Directed bench for crossbar_nxn_rr (N=4, W=4); counter tests run when
// XBAR_CNT_EN is defined.
module tb_crossbar_nxn_rr;

  localparam int N  = 4;
  localparam int W  = 4;
  localparam int DW = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_ready;
  logic [N*DW-1:0] in_dest;
  logic [N*W-1:0]  in_data;
  logic [N-1:0]    out_valid;
  logic [N-1:0]    out_ready;
  logic [N*DW-1:0] out_src;
  logic [N*W-1:0]  out_data;
`ifdef XBAR_CNT_EN
  logic [N*16-1:0] out_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;

  crossbar_nxn_rr #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_dest   (in_dest),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_src   (out_src),
    .out_data  (out_data)
`ifdef XBAR_CNT_EN
    ,
    .out_cnt   (out_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 4'b1111;
    in_dest = 8'h1B;
    in_data = 16'h4321;
    out_ready = 4'b1111;
    tick();
    tick();
    vectors++;
    if (in_ready !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_in_ready got=%b exp=0000", in_ready);
    end
    vectors++;
    if (out_valid !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_out_valid got=%b exp=0000", out_valid);
    end
    vectors++;
    if (out_data !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset_out_data got=%h exp=0000", out_data);
    end
    in_valid = '0;
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_contention();
    int exp;
    in_valid = 4'b1111;
    in_dest = 8'hAA;
    in_data = 16'hBA98;
    out_ready = 4'b1111;
    #1;
    for (int k = 0; k < 5; k++) begin
      exp = k % 4;
      vectors++;
      if (in_ready !== 4'(1 << exp)) begin
        miscompares++;
        $display("FAIL contention_ready[%0d] got=%b exp=%b", k, in_ready, 4'(1 << exp));
      end
      tick();
      vectors++;
      if (out_src[5:4] !== 2'(exp) || out_data[11:8] !== 4'(8 + exp) || out_valid[2] !== 1'b1) begin
        miscompares++;
        $display("FAIL contention_out[%0d] got src=%0d data=%h vld=%b exp src=%0d data=%h vld=1",
                 k, out_src[5:4], out_data[11:8], out_valid[2], exp, 8 + exp);
      end
    end
    in_valid = '0;
    tick();
  endtask

  task automatic test_permutation();
    in_valid = 4'b1111;
    in_dest = 8'h1B;
    in_data = 16'h4321;
    out_ready = 4'b1111;
    #1;
    vectors++;
    if (in_ready !== 4'b1111) begin
      miscompares++;
      $display("FAIL perm_in_ready got=%b exp=1111", in_ready);
    end
    tick();
    in_valid = '0;
    #1;
    vectors++;
    if (out_valid !== 4'b1111) begin
      miscompares++;
      $display("FAIL perm_out_valid got=%b exp=1111", out_valid);
    end
    vectors++;
    if (out_data !== 16'h1234) begin
      miscompares++;
      $display("FAIL perm_out_data got=%h exp=1234", out_data);
    end
    vectors++;
    if (out_src !== 8'h1B) begin
      miscompares++;
      $display("FAIL perm_out_src got=%h exp=1b", out_src);
    end
    tick();
    vectors++;
    if (out_valid !== 4'b0000) begin
      miscompares++;
      $display("FAIL perm_drain got=%b exp=0000", out_valid);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 4'b1101;
    in_valid = 4'b0100;
    in_dest = 8'h10;
    in_data = 16'h0500;
    tick();
    in_valid = 4'b0001;
    in_dest = 8'h01;
    in_data = 16'h0007;
    #1;
    for (int k = 0; k < 5; k++) begin
      vectors++;
      if (in_ready[0] !== 1'b0 || out_valid[1] !== 1'b1 || out_data[7:4] !== 4'h5) begin
        miscompares++;
        $display("FAIL bp_hold[%0d] got rdy=%b vld=%b data=%h exp rdy=0 vld=1 data=5",
                 k, in_ready[0], out_valid[1], out_data[7:4]);
      end
      tick();
    end
    out_ready = 4'b1111;
    #1;
    vectors++;
    if (in_ready !== 4'b0001) begin
      miscompares++;
      $display("FAIL bp_release_ready got=%b exp=0001", in_ready);
    end
    tick();
    in_valid = '0;
    #1;
    vectors++;
    if (out_valid[1] !== 1'b1 || out_data[7:4] !== 4'h7 || out_src[3:2] !== 2'd0) begin
      miscompares++;
      $display("FAIL bp_refill got vld=%b data=%h src=%0d exp vld=1 data=7 src=0",
               out_valid[1], out_data[7:4], out_src[3:2]);
    end
    tick();
  endtask

  task automatic test_ptr_after_reset();
    out_ready = 4'b1111;
    in_valid = 4'b0100;
    in_dest = 8'h20;
    in_data = 16'h0100;
    tick();
    in_valid = '0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    in_valid = 4'b1010;
    in_dest = 8'h88;
    in_data = 16'hC0D0;
    #1;
    vectors++;
    if (in_ready !== 4'b0010) begin
      miscompares++;
      $display("FAIL ptr_reset_ready got=%b exp=0010", in_ready);
    end
    tick();
    vectors++;
    if (out_src[5:4] !== 2'd1 || out_data[11:8] !== 4'hD) begin
      miscompares++;
      $display("FAIL ptr_reset_src got src=%0d data=%h exp src=1 data=d", out_src[5:4], out_data[11:8]);
    end
    in_valid = '0;
    tick();
  endtask

  task automatic test_async_reset();
    out_ready = 4'b0000;
    in_valid = 4'b0001;
    in_dest = 8'h00;
    in_data = 16'h0009;
    tick();
    in_valid = '0;
    vectors++;
    if (out_valid[0] !== 1'b1 || out_data[3:0] !== 4'h9) begin
      miscompares++;
      $display("FAIL async_setup got vld=%b data=%h exp vld=1 data=9", out_valid[0], out_data[3:0]);
    end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 4'b0000) begin
      miscompares++;
      $display("FAIL async_out_valid got=%b exp=0000", out_valid);
    end
    vectors++;
    if (out_data !== 16'h0000) begin
      miscompares++;
      $display("FAIL async_out_data got=%h exp=0000", out_data);
    end
    tick();
    rst_n = 1'b1;
    out_ready = 4'b1111;
    #1;
  endtask

`ifdef XBAR_CNT_EN
  task automatic test_counter();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    out_ready = 4'b1111;
    in_valid = 4'b0001;
    in_dest = 8'h01;
    in_data = 16'h0003;
    for (int k = 0; k < 3; k++) tick();
    in_valid = '0;
    #1;
    vectors++;
    if (out_cnt !== 64'h0000_0000_0003_0000) begin
      miscompares++;
      $display("FAIL cnt_three got=%h exp=0000000000030000", out_cnt);
    end
    in_valid = 4'b0001;
    in_dest = 8'h00;
    for (int k = 0; k < 65535; k++) tick();
    vectors++;
    if (out_cnt[15:0] !== 16'hFFFF) begin
      miscompares++;
      $display("FAIL cnt_max got=%h exp=ffff", out_cnt[15:0]);
    end
    tick();
    in_valid = '0;
    #1;
    vectors++;
    if (out_cnt !== 64'h0000_0000_0003_0000) begin
      miscompares++;
      $display("FAIL cnt_wrap got=%h exp=0000000000030000", out_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_contention();
    test_permutation();
    test_backpressure();
    test_ptr_after_reset();
    test_async_reset();
`ifdef XBAR_CNT_EN
    test_counter();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/crossbar_nxn_rr.md
# crossbar_nxn_rr

Parametrised N×N registered crossbar switch with per-output round-robin arbitration and valid/ready flow control. It is the next generation of the team's fixed 4×4 4-bit control-word crossbar. Routing comes from a per-input destination field rather than a static control vector, so several inputs may contend for one output. It sits between N producer lanes and N consumer lanes and buffers one word per output.

## Interface
Parameters:
- `N`, default 4: port count; power of two, ≥2
- `W`, default 4: data width per lane
- `DW`, default `$clog2(N)`: destination/source index width; derived, not overridden

Ports:
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  reset; asynchronous, active-low
- `in_valid`  in  N  input i offers a word
- `in_ready`  out  N  input i's word is accepted this cycle
- `in_dest`  in  N*DW  destination output index of input i, slice [i*DW +: DW]
- `in_data`  in  N*W  data of input i, slice [i*W +: W]
- `out_valid`  out  N  output j holds a word
- `out_ready`  in  N  consumer j takes the word this cycle
- `out_src`  out  N*DW  input index the word in output j came from
- `out_data`  out  N*W  data held in output j
- `out_cnt`  out  N*16  per-output transfer counters; present only with `XBAR_CNT_EN`

## Operation
- Transfer rule: a transfer on input i occurs when `in_valid[i] & in_ready[i]`. A transfer on output j occurs when `out_valid[j] & out_ready[j]`.
- Per output j:
  - `req_j[i] = in_valid[i] & (in_dest_i == j)`
  - `free_j = ~out_valid[j] | out_ready[j]`
- Arbiter j grants one requester when `free_j` is set. Search starts at `ptr[j]` and goes upward modulo N; the first set `req_j` bit wins.
- `in_ready[i]` is set only when input i is granted by output `in_dest_i`. It is combinational from valid, dest and state. Valid never depends on ready.
- Each input requests at most one output, so no input is granted twice.
- On a grant to input g at output j, at the clock edge:
  - `out_data[j] <= in_data_g`, `out_src[j] <= g`, `out_valid[j] <= 1`
  - `ptr[j] <= (g+1) mod N`
- On an output transfer with no new grant, `out_valid[j] <= 0`. `out_data` and `out_src` keep their last values.
- When `free_j` is 0, `out_data[j]`, `out_src[j]` and `ptr[j]` hold.
- A drain and a refill on the same output in the same cycle is allowed. This gives full throughput: one word per output per cycle.
- No requests at output j: `ptr[j]` is unchanged.
- During reset (`rst_n` = 0), `in_ready` is forced to 0.

## Timing
- Latency: a word accepted at edge k is visible on `out_valid` and `out_data` after edge k, i.e. in cycle k+1. Data is registered.
- `in_ready` is combinational; its path runs through the arbiter from `in_valid`, `in_dest` and `out_ready`.
- Reset values: `out_valid`=0, `out_data`=0, `out_src`=0, `ptr[*]`=0, `out_cnt`=0. These take effect immediately on `rst_n` falling, with no clock needed. In-flight words are discarded.
- After `rst_n` rises, the first edge may already accept data.
- Fairness: under continuous contention of M requesters for one always-ready output, each requester is granted exactly once per M cycles.

## Configuration
- `XBAR_CNT_EN` defined:
  - adds `out_cnt`, one 16-bit counter per output
  - counter j increments on every input-side grant into output j
  - wraps 16'hFFFF → 0
  - reset 0
- Not defined: port absent; no counter logic.

## Structure
- Shared package `xbar_pkg`:
  - `CNT_W` = 16
  - helper function for slice extraction of packed lane vectors
- Sub-module `rr_arbiter`:
  - parameter N
  - inputs: `req[N]`, `ptr[DW]`, `en`
  - outputs: one-hot `gnt[N]`, `gnt_idx[DW]`, `any`
  - purely combinational
  - instantiated N times, one per output; pointer registers live in the top.

## Test plan
N=4, W=4.
- Reset: hold `rst_n`=0 with all `in_valid`=1 → `in_ready`=0000, `out_valid`=0000, `out_data`=0. Drop `rst_n` mid-run while `out_valid[0]`=1 → `out_valid[0]` clears without a clock edge.
- Permutation: input i sends dest=3-i, data=i+1, all `out_ready`=1 → `in_ready`=1111. Next cycle `out_valid`=1111, `out_data[3]`=1 with `out_src[3]`=0, `out_data[0]`=4 with `out_src[0]`=3.
- Contention: all inputs dest=2, data=8+i, held valid, `out_ready[2]`=1 → `out_src[2]` sequence 0,1,2,3,0. Exactly one `in_ready` bit high per cycle.
- Backpressure: `out_valid[1]`=1, `out_ready[1]`=0, input 0 sends dest=1 → `in_ready[0]`=0 and `out_data[1]` stable for 5 cycles. Raise `out_ready[1]` → output drains and accepts input 0 in the same cycle, `out_valid[1]` stays 1.
- Pointer after reset: with `ptr[2]`=3 before reset, assert then release reset, then inputs 1 and 3 both target output 2 → input 1 is granted first.
- `XBAR_CNT_EN`: 3 transfers into output 1 → `out_cnt[1]`=3, others 0. 65536 transfers into output 0 → `out_cnt[0]` wraps to 0.
